// File: rtl/text_console_pkg.sv
// Shared constants and the controller state type for the text console writer.
`timescale 1ns/1ps
package text_console_pkg;
  localparam int PHYS_ROWS = 64;
  localparam int ADDR_W    = 13;

  localparam logic [7:0] CODE_BS    = 8'h08;
  localparam logic [7:0] CODE_LF    = 8'h0A;
  localparam logic [7:0] CODE_FF    = 8'h0C;
  localparam logic [7:0] CODE_CR    = 8'h0D;
  localparam logic [7:0] CODE_SPACE = 8'h20;

  typedef enum logic [1:0] {
    INIT_CLEAR,
    IDLE,
    SCROLL_CLEAR,
    FF_CLEAR
  } state_t;
endpackage

// File: rtl/text_row_clear.sv
// Walks row_count physical rows (6-bit wrapping) column by column, one write per cycle.
`timescale 1ns/1ps
module text_row_clear #(
  parameter int COLS = 80
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        start,
  input  logic [5:0]  first_row,
  input  logic [5:0]  row_count,
  output logic [12:0] address,
  output logic        wr_en,
  output logic        done
);
  logic       active_reg;
  logic [5:0] row_reg;
  logic [5:0] rows_left_reg;
  logic [6:0] col_reg;
  logic       last_col;

  assign last_col = (col_reg == 7'(COLS - 1));
  assign wr_en    = active_reg;
  assign address  = {row_reg, col_reg};
  assign done     = active_reg && last_col && (rows_left_reg == 6'd1);

  always_ff @(posedge clk) begin
    if (srst) begin
      active_reg    <= 1'b0;
      row_reg       <= '0;
      rows_left_reg <= '0;
      col_reg       <= '0;
    end else if (start) begin
      active_reg    <= 1'b1;
      row_reg       <= first_row;
      rows_left_reg <= row_count;
      col_reg       <= '0;
    end else if (active_reg) begin
      if (last_col) begin
        col_reg       <= '0;
        row_reg       <= row_reg + 6'd1;
        rows_left_reg <= rows_left_reg - 6'd1;
        if (done) active_reg <= 1'b0;
      end else begin
        col_reg <= col_reg + 7'd1;
      end
    end
  end
endmodule

// File: rtl/text_console_writer.sv
// Host character stream to text/attribute RAM writer with cursor, hardware scroll and clears.
`timescale 1ns/1ps
module text_console_writer
  import text_console_pkg::*;
#(
  parameter int         COLS         = 80,
  parameter int         ROWS         = 30,
  parameter logic [7:0] DEFAULT_ATTR = 8'h0F
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [7:0]          IN_DATA,
  input  logic [7:0]          IN_ATTR,
  input  logic                IN_VALID,
  output logic                IN_READY,
  output logic [ADDR_W-1:0]   WR_ADDRESS,
  output logic [7:0]          WR_CHAR_DATA,
  output logic [7:0]          WR_ATTR_DATA,
  output logic                WR_EN,
  output logic [7:0]          ROW_OFFSET,
  output logic [6:0]          CURSOR_COL,
  output logic [4:0]          CURSOR_ROW,
  output logic                BUSY
);
  localparam logic [5:0] ROWS6 = 6'(ROWS);

  state_t      state_reg, state_next;
  logic [6:0]  col_reg, col_next;
  logic [4:0]  row_reg, row_next;
  logic [5:0]  offset_reg, offset_next;
  logic [12:0] wr_addr_reg, wr_addr_next;
  logic [7:0]  wr_char_reg, wr_char_next;
  logic [7:0]  wr_attr_reg, wr_attr_next;
  logic        wr_en_reg, wr_en_next;
  logic        ready_reg, busy_reg;
  logic        newline;

  logic        clr_start;
  logic [5:0]  clr_first, clr_count;
  logic [12:0] clr_addr;
  logic        clr_wr, clr_done;
  logic [5:0]  phys_cursor;

  assign phys_cursor = offset_reg + {1'b0, row_reg};

  text_row_clear #(.COLS(COLS)) u_clear (
    .clk       (CLK),
    .srst      (RST),
    .start     (clr_start),
    .first_row (clr_first),
    .row_count (clr_count),
    .address   (clr_addr),
    .wr_en     (clr_wr),
    .done      (clr_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= INIT_CLEAR;
      col_reg     <= '0;
      row_reg     <= '0;
      offset_reg  <= '0;
      wr_addr_reg <= '0;
      wr_char_reg <= '0;
      wr_attr_reg <= '0;
      wr_en_reg   <= 1'b0;
      ready_reg   <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      col_reg     <= col_next;
      row_reg     <= row_next;
      offset_reg  <= offset_next;
      wr_addr_reg <= wr_addr_next;
      wr_char_reg <= wr_char_next;
      wr_attr_reg <= wr_attr_next;
      wr_en_reg   <= wr_en_next;
      ready_reg   <= (state_next == IDLE);
      busy_reg    <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next   = state_reg;
    col_next     = col_reg;
    row_next     = row_reg;
    offset_next  = offset_reg;
    wr_addr_next = wr_addr_reg;
    wr_char_next = wr_char_reg;
    wr_attr_next = wr_attr_reg;
    wr_en_next   = 1'b0;
    newline      = 1'b0;
    clr_start    = 1'b0;
    clr_first    = offset_reg;
    clr_count    = ROWS6;

    case (state_reg)
      INIT_CLEAR: begin
        // Kick the walker once after reset; it stays active until its final write.
        if (!clr_wr) begin
          clr_start = 1'b1;
          clr_first = 6'd0;
        end
        if (clr_done) state_next = IDLE;
      end
      SCROLL_CLEAR, FF_CLEAR: begin
        if (clr_done) state_next = IDLE;
      end
      IDLE: begin
        if (IN_VALID) begin
          if (IN_DATA >= CODE_SPACE) begin
            wr_en_next   = 1'b1;
            wr_addr_next = {phys_cursor, col_reg};
            wr_char_next = IN_DATA;
            wr_attr_next = IN_ATTR;
            if (col_reg == 7'(COLS - 1)) begin
              col_next = '0;
              newline  = 1'b1;
            end else begin
              col_next = col_reg + 7'd1;
            end
          end else begin
            case (IN_DATA)
              CODE_CR: col_next = '0;
              CODE_LF: begin
                col_next = '0;
                newline  = 1'b1;
              end
              CODE_BS: if (col_reg != 7'd0) col_next = col_reg - 7'd1;
              CODE_FF: begin
                state_next = FF_CLEAR;
                clr_start  = 1'b1;
                col_next   = '0;
                row_next   = '0;
              end
              default: ;
            endcase
          end

          if (newline) begin
            if (row_reg < 5'(ROWS - 1)) begin
              row_next = row_reg + 5'd1;
            end else begin
              // New bottom row is (new offset + ROWS-1), i.e. old offset + ROWS.
              offset_next = offset_reg + 6'd1;
              clr_start   = 1'b1;
              clr_first   = offset_reg + ROWS6;
              clr_count   = 6'd1;
              state_next  = SCROLL_CLEAR;
            end
          end
        end
      end
      default: state_next = INIT_CLEAR;
    endcase

    if (clr_wr) begin
      wr_en_next   = 1'b1;
      wr_addr_next = clr_addr;
      wr_char_next = CODE_SPACE;
      wr_attr_next = DEFAULT_ATTR;
    end
  end

  assign IN_READY     = ready_reg;
  assign BUSY         = busy_reg;
  assign WR_EN        = wr_en_reg;
  assign WR_ADDRESS   = wr_addr_reg;
  assign WR_CHAR_DATA = wr_char_reg;
  assign WR_ATTR_DATA = wr_attr_reg;
  assign ROW_OFFSET   = {2'b00, offset_reg};
  assign CURSOR_COL   = col_reg;
  assign CURSOR_ROW   = row_reg;
endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench: stimulus queues expected RAM writes, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_text_console_writer;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  IN_DATA = '0;
  logic [7:0]  IN_ATTR = '0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [12:0] WR_ADDRESS;
  logic [7:0]  WR_CHAR_DATA, WR_ATTR_DATA;
  logic        WR_EN;
  logic [7:0]  ROW_OFFSET;
  logic [6:0]  CURSOR_COL;
  logic [4:0]  CURSOR_ROW;
  logic        BUSY;

  int checks = 0;
  int errors = 0;
  logic [28:0] exp_q[$];

  text_console_writer #(.COLS(80), .ROWS(30), .DEFAULT_ATTR(8'h0F)) dut (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_ATTR(IN_ATTR), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .WR_ADDRESS(WR_ADDRESS), .WR_CHAR_DATA(WR_CHAR_DATA),
    .WR_ATTR_DATA(WR_ATTR_DATA), .WR_EN(WR_EN), .ROW_OFFSET(ROW_OFFSET),
    .CURSOR_COL(CURSOR_COL), .CURSOR_ROW(CURSOR_ROW), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Write monitor
  always @(negedge CLK) begin
    if (WR_EN === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr %h data %h/%h, required no write",
                 WR_ADDRESS, WR_CHAR_DATA, WR_ATTR_DATA);
      end else begin
        logic [28:0] e;
        e = exp_q.pop_front();
        if ({WR_ADDRESS, WR_CHAR_DATA, WR_ATTR_DATA} !== e) begin
          errors++;
          $display("FAIL wr_data: got addr %h data %h/%h, required addr %h data %h/%h",
                   WR_ADDRESS, WR_CHAR_DATA, WR_ATTR_DATA, e[28:16], e[15:8], e[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_write(input int row, input int col, input logic [7:0] ch, input logic [7:0] at);
    exp_q.push_back({6'(row), 7'(col), ch, at});
  endtask

  task automatic push_clear(input int first_row, input int nrows);
    for (int r = 0; r < nrows; r++)
      for (int c = 0; c < 80; c++)
        exp_q.push_back({6'(first_row + r), 7'(c), 8'h20, 8'h0F});
  endtask

  task automatic wait_ready(input int max, input string name);
    int n = 0;
    while (IN_READY !== 1'b1 && n < max) begin
      step();
      n++;
    end
    check(name, 32'(IN_READY), 32'd1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      step();
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] a);
    wait_ready(3000, "ready_before_send");
    IN_DATA  = d;
    IN_ATTR  = a;
    IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    $display("send %h attr %h -> cursor col %0d row %0d offset %0d",
             d, a, CURSOR_COL, CURSOR_ROW, ROW_OFFSET);
  endtask

  initial begin
    int n;
    RST = 1'b1;
    repeat (3) step();
    check("rst_wr_en", 32'(WR_EN), 0);
    check("rst_ready", 32'(IN_READY), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_offset", 32'(ROW_OFFSET), 0);
    check("rst_col", 32'(CURSOR_COL), 0);
    check("rst_row", 32'(CURSOR_ROW), 0);
    check("rst_addr", 32'(WR_ADDRESS), 0);

    push_clear(0, 30);
    RST = 1'b0;
    step();
    check("init_busy", 32'(BUSY), 1);
    check("init_ready_low", 32'(IN_READY), 0);
    wait_ready(3000, "init_done");
    check("init_offset", 32'(ROW_OFFSET), 0);
    check("init_busy_low", 32'(BUSY), 0);
    drain("init_writes");

    push_write(0, 0, 8'h41, 8'h1E);
    send(8'h41, 8'h1E);
    check("a_col", 32'(CURSOR_COL), 1);
    check("a_row", 32'(CURSOR_ROW), 0);
    send(8'h0D, 8'h00);
    check("cr_col", 32'(CURSOR_COL), 0);

    for (int i = 0; i < 80; i++) begin
      push_write(0, i, 8'(8'h21 + i), 8'h07);
      send(8'(8'h21 + i), 8'h07);
    end
    check("row0_full_col", 32'(CURSOR_COL), 0);
    check("row0_full_row", 32'(CURSOR_ROW), 1);
    drain("row0_writes");

    send(8'h08, 8'h00);
    check("bs_sat_col", 32'(CURSOR_COL), 0);
    push_write(1, 0, 8'h42, 8'h07);
    send(8'h42, 8'h07);
    check("b_col", 32'(CURSOR_COL), 1);
    send(8'h08, 8'h00);
    check("bs_col", 32'(CURSOR_COL), 0);
    send(8'h01, 8'h00);
    check("ignored_col", 32'(CURSOR_COL), 0);
    check("ignored_row", 32'(CURSOR_ROW), 1);

    for (int i = 0; i < 28; i++) send(8'h0A, 8'h00);
    check("lf_row29", 32'(CURSOR_ROW), 29);
    push_write(29, 0, 8'h43, 8'h07);
    send(8'h43, 8'h07);
    check("c_col", 32'(CURSOR_COL), 1);

    push_clear(30, 1);
    send(8'h0A, 8'h00);
    n = 0;
    while (IN_READY === 1'b0 && n < 200) begin
      n++;
      step();
    end
    check("scroll_ready_low_cycles", 32'(n), 80);
    check("scroll_offset", 32'(ROW_OFFSET), 1);
    check("scroll_row", 32'(CURSOR_ROW), 29);
    check("scroll_col", 32'(CURSOR_COL), 0);
    drain("scroll_writes");

    for (int k = 2; k <= 64; k++) begin
      push_clear(((k % 64) + 29) % 64, 1);
      send(8'h0A, 8'h00);
      wait_ready(200, "scroll_loop_ready");
      drain("scroll_loop_writes");
    end
    check("scroll64_offset", 32'(ROW_OFFSET), 0);

    push_clear(30, 1);
    send(8'h0A, 8'h00);
    wait_ready(200, "scroll65_ready");
    drain("scroll65_writes");
    check("scroll65_offset", 32'(ROW_OFFSET), 1);

    push_clear(1, 30);
    send(8'h0C, 8'h00);
    check("ff_busy", 32'(BUSY), 1);
    wait_ready(3000, "ff_done");
    check("ff_col", 32'(CURSOR_COL), 0);
    check("ff_row", 32'(CURSOR_ROW), 0);
    check("ff_offset", 32'(ROW_OFFSET), 1);
    drain("ff_writes");
    push_write(1, 0, 8'h5A, 8'h2A);
    send(8'h5A, 8'h2A);
    check("z_col", 32'(CURSOR_COL), 1);
    drain("z_write");

    push_clear(1, 30);
    send(8'h0C, 8'h00);
    repeat (100) step();
    RST = 1'b1;
    @(negedge CLK);
    step();
    exp_q.delete();
    check("midrst_wr_en", 32'(WR_EN), 0);
    check("midrst_busy", 32'(BUSY), 0);
    check("midrst_offset", 32'(ROW_OFFSET), 0);
    check("midrst_col", 32'(CURSOR_COL), 0);
    check("midrst_row", 32'(CURSOR_ROW), 0);
    push_clear(0, 30);
    RST = 1'b0;
    wait_ready(3000, "midrst_init_done");
    drain("midrst_init_writes");
    check("midrst_final_offset", 32'(ROW_OFFSET), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/text_console_writer.md
TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

Interface
REQ-001: Parameter COLS, default 80, text columns per row.
REQ-002: Parameter ROWS, default 30, visible text rows.
REQ-003: Parameter DEFAULT_ATTR, default 8'h0F, attribute written by all clear operations.
REQ-004: One clock; reset is synchronous and active-high.
REQ-005: CLK  in  1  sole clock; all logic on rising edge.
REQ-006: RST  in  1  synchronous active-high reset.
REQ-007: IN_DATA  in  8  character or control code from host.
REQ-008: IN_ATTR  in  8  attribute stored with IN_DATA.
REQ-009: IN_VALID  in  1  IN_DATA/IN_ATTR valid.
REQ-010: IN_READY  out  1  block accepts; transfer when IN_VALID and IN_READY both high.
REQ-011: WR_ADDRESS  out  13  text-RAM write address {phys_row[5:0], col[6:0]}.
REQ-012: WR_CHAR_DATA  out  8  character-RAM write data.
REQ-013: WR_ATTR_DATA  out  8  attribute-RAM write data.
REQ-014: WR_EN  out  1  write strobe for both RAMs, one write per cycle.
REQ-015: ROW_OFFSET  out  8  scroll offset in text rows, [7:6] always 0; drives the display's RAM_ROW_OFFSET.
REQ-016: CURSOR_COL  out  7  current column, 0..COLS-1.
REQ-017: CURSOR_ROW  out  5  current visible row, 0..ROWS-1.
REQ-018: BUSY  out  1  high in any clear state.

Function
REQ-019: Physical RAM holds 64 rows; visible row r maps to phys_row = (ROW_OFFSET + r) mod 64.
REQ-020: States: INIT_CLEAR, IDLE, SCROLL_CLEAR, FF_CLEAR; IN_READY = 1 only in IDLE.
REQ-021: Codes >= 8'h20 printable: WR_EN high the cycle after acceptance, address {phys(CURSOR_ROW), CURSOR_COL}, data IN_DATA/IN_ATTR; latency 1 cycle.
REQ-022: After printable write, CURSOR_COL increments; at CURSOR_COL = COLS-1 it wraps to 0 and a newline occurs.
REQ-023: 8'h0D (CR): CURSOR_COL <= 0, no write.
REQ-024: 8'h0A (LF): CURSOR_COL <= 0 and newline.
REQ-025: 8'h08 (BS): CURSOR_COL decrements, saturates at 0, no write.
REQ-026: 8'h0C (FF): enter FF_CLEAR; other codes < 8'h20 ignored, consumed in one cycle.
REQ-027: Newline with CURSOR_ROW < ROWS-1: CURSOR_ROW increments, stay IDLE.
REQ-028: Newline with CURSOR_ROW = ROWS-1: ROW_OFFSET <= (ROW_OFFSET+1) mod 64, CURSOR_ROW unchanged, enter SCROLL_CLEAR.
REQ-029: SCROLL_CLEAR writes 8'h20/DEFAULT_ATTR to cols 0..COLS-1 of phys row (new ROW_OFFSET + ROWS-1) mod 64, one per cycle, then IDLE; exactly COLS cycles with IN_READY low.
REQ-030: FF_CLEAR writes 8'h20/DEFAULT_ATTR to all visible rows 0..ROWS-1 (COLS*ROWS cycles, row-major), ROW_OFFSET unchanged, cursor <= (0,0), then IDLE.
REQ-031: IN_VALID low in IDLE: no WR_EN, no state change.
REQ-032: Clear address counters never emit col >= COLS.
REQ-033: ROW_OFFSET wrap 63 -> 0 is seamless; phys arithmetic is 6-bit modulo.

Reset
REQ-034: RST high: WR_EN 0, IN_READY 0, BUSY 0, ROW_OFFSET 0, cursor (0,0), WR_* 0, state INIT_CLEAR.
REQ-035: INIT_CLEAR behaves as FF_CLEAR with ROW_OFFSET 0 (2400 cycles by default), then IDLE.
REQ-036: RST asserted during any clear aborts it; clearing restarts from address 0 in INIT_CLEAR.

Structure
REQ-037: Package text_console_pkg holds PHYS_ROWS=64, ADDR_W=13, CR/LF/BS/FF code constants and the state enum.
REQ-038: One sub-module text_row_clear: start, first row, row count; emits address/WR_EN sequence and done.

Verification
REQ-039: Reset, hold IN_VALID low -> 2400 WR_EN pulses data 8'h20/8'h0F, then IN_READY 1, ROW_OFFSET 0.
REQ-040: Send 'A' attr 8'h1E at (0,0) -> next cycle WR_EN, address 13'h0000, data 8'h41/8'h1E; CURSOR_COL 1.
REQ-041: Send 80 printable chars on row 0 -> last at address 13'h004F; cursor (col 0, row 1).
REQ-042: Cursor row 29, send LF -> ROW_OFFSET 1, IN_READY low 80 cycles, clears addresses {6'd30, 0..79}.
REQ-043: 64 scrolls from offset 0 -> ROW_OFFSET returns to 0; 64th scroll clears phys row 29.
REQ-044: Assert RST midway through FF_CLEAR -> cursor (0,0), offset 0, INIT_CLEAR restarts at address 0.
